// File: rtl/sram_responder.sv
// sram_responder: 16-bit word SRAM behind the SLC-3 memory port.
// Optional power-up program-image load from an external ROM is built
// when SRAM_INIT_EN is defined; otherwise the array starts undefined.
module sram_responder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              OE,
  input  logic              WE,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       Data_to_SRAM,
  output logic [15:0]       Data_from_SRAM,
  output logic [ADDR_W-1:0] Init_Addr,
  input  logic [15:0]       Init_Data,
  output logic              Busy,
  output logic              Range_Err
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam logic [15:0] LO_MASK = 16'((32'd1 << ADDR_W) - 32'd1);

  logic [15:0]       mem [DEPTH];
  logic              load_active;
  logic              in_range;
  logic [ADDR_W-1:0] cpu_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;

  assign in_range = (ADDR & ~LO_MASK) == '0;
  assign cpu_addr = ADDR[ADDR_W-1:0];

`ifdef SRAM_INIT_EN
  typedef enum logic {LOAD, SERVE} state_t;

  state_t state;
  state_t state_nxt;

  // State register; reset always restarts the image load
  always_ff @(posedge Clk) begin
    if (Reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // Next state: leave LOAD on the cycle that writes the last word
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (Init_Addr == '1) state_nxt = SERVE;
      SERVE:   state_nxt = SERVE;
      default: state_nxt = LOAD;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    load_active = (state == LOAD);
    Busy        = load_active;
  end

  // ROM address counter; natural wrap leaves it at 0 after the last word
  always_ff @(posedge Clk) begin
    if (Reset)            Init_Addr <= '0;
    else if (load_active) Init_Addr <= Init_Addr + 1'b1;
  end
`else
  logic unused_init_data;

  // No image load in this build
  always_comb begin
    load_active      = 1'b0;
    Busy             = 1'b0;
    Init_Addr        = '0;
    unused_init_data = ^Init_Data;
  end
`endif

  // Single write port shared by the image load and CPU writes
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cpu_addr;
    mem_wdata = Data_to_SRAM;
    if (!Reset) begin
      if (load_active) begin
        mem_we    = 1'b1;
        mem_waddr = Init_Addr;
        mem_wdata = Init_Data;
      end else if (!WE && in_range) begin
        mem_we = 1'b1;
      end
    end
  end

  // Memory array; not reset so contents survive Reset
  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read data and range-error pulse
  always_ff @(posedge Clk) begin
    if (Reset || load_active) begin
      Data_from_SRAM <= '0;
      Range_Err      <= 1'b0;
    end else begin
      Range_Err <= !in_range && (!OE || !WE);
      if (!OE) begin
        if (!in_range) Data_from_SRAM <= '0;
        else if (!WE)  Data_from_SRAM <= Data_to_SRAM;
        else           Data_from_SRAM <= mem[cpu_addr];
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder (ADDR_W=4); follows SRAM_INIT_EN if defined.
module tb_sram_responder;

  logic        clk;
  logic        rst;
  logic        oe;
  logic        we;
  logic [15:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic [3:0]  init_addr;
  logic [15:0] init_data;
  logic        busy;
  logic        rerr;

  int n_vec;
  int n_err;

  // reference model state
  logic [15:0] ref_mem [16];
  bit          ref_vld [16];
  logic [15:0] m_dout;
  bit          m_known;
  bit          m_rerr;
  bit          m_loading;
  int          m_idx;

  sram_responder #(.ADDR_W(4)) dut (
    .Clk            (clk),
    .Reset          (rst),
    .OE             (oe),
    .WE             (we),
    .ADDR           (addr),
    .Data_to_SRAM   (din),
    .Data_from_SRAM (dout),
    .Init_Addr      (init_addr),
    .Init_Data      (init_data),
    .Busy           (busy),
    .Range_Err      (rerr)
  );

  // program-image ROM: word i holds 0x1000 + i
  assign init_data = 16'h1000 + {12'h000, init_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit o, input bit w, input logic [15:0] a, input logic [15:0] d);
    rst  = r;
    oe   = o;
    we   = w;
    addr = a;
    din  = d;
  endtask

  // apply current inputs across one rising edge, update model, compare
  task automatic cycle();
    bit in_rng;
    int a;
    in_rng = (addr < 16'd16);
    a      = int'(addr[3:0]);
    if (rst) begin
      m_dout  = '0;
      m_known = 1;
      m_rerr  = 0;
      m_idx   = 0;
`ifdef SRAM_INIT_EN
      m_loading = 1;
`else
      m_loading = 0;
`endif
    end else if (m_loading) begin
      ref_mem[m_idx] = 16'h1000 + 16'(m_idx);
      ref_vld[m_idx] = 1;
      m_idx++;
      if (m_idx == 16) begin
        m_loading = 0;
        m_idx     = 0;
      end
      m_dout  = '0;
      m_known = 1;
      m_rerr  = 0;
    end else begin
      m_rerr = !in_rng && (!oe || !we);
      if (!oe) begin
        if (!in_rng) begin
          m_dout  = '0;
          m_known = 1;
        end else if (!we) begin
          m_dout  = din;
          m_known = 1;
        end else begin
          m_dout  = ref_mem[a];
          m_known = ref_vld[a];
        end
      end
      if (!we && in_rng) begin
        ref_mem[a] = din;
        ref_vld[a] = 1;
      end
    end
    @(posedge clk);
    #1;
    if (m_known) chk("dout", dout, m_dout);
    chk("range_err", {15'd0, rerr}, {15'd0, m_rerr});
    chk("busy", {15'd0, busy}, {15'd0, m_loading});
    chk("init_addr", {12'd0, init_addr}, 16'(m_idx));
  endtask

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;
    m_known = 0;
    m_loading = 0;
    m_idx = 0;
    m_rerr = 0;
    m_dout = '0;
    for (int i = 0; i < 16; i++) ref_vld[i] = 0;
    drive(1, 1, 1, 16'h0000, 16'h0000);
    @(negedge clk);

    // reset state
    cycle();
    chk("rst_dout", dout, 16'h0000);
    chk("rst_rerr", {15'd0, rerr}, 16'h0000);
    chk("rst_init_addr", {12'd0, init_addr}, 16'h0000);
    drive(0, 1, 1, 16'h0000, 16'h0000);

`ifdef SRAM_INIT_EN
    // mid-load reset at Init_Addr 7, CPU write attempted throughout
    for (int i = 0; i < 7; i++) cycle();
    chk("mid_init_addr", {12'd0, init_addr}, 16'h0007);
    drive(1, 0, 0, 16'h0003, 16'hDEAD);
    cycle();
    chk("reload_init_addr", {12'd0, init_addr}, 16'h0000);
    chk("reload_busy", {15'd0, busy}, 16'h0001);
    drive(0, 0, 0, 16'h0003, 16'hDEAD);
    n = 0;
    while (busy && n < 40) begin
      n++;
      cycle();
    end
    chk("load_cycles", 16'(n), 16'd16);
    drive(0, 0, 1, 16'h0003, 16'h0000);
    cycle();
    chk("no_write_in_load", dout, 16'h1003);
    drive(0, 0, 1, 16'h0005, 16'h0000);
    cycle();
    chk("image_read5", dout, 16'h1005);
`else
    chk("busy_after_rst", {15'd0, busy}, 16'h0000);
    drive(0, 1, 0, 16'h0001, 16'hC0DE);
    cycle();
    drive(0, 0, 1, 16'h0001, 16'h0000);
    cycle();
    chk("wr_rd_0001", dout, 16'hC0DE);
    drive(0, 1, 0, 16'h0000, 16'h5A5A);
    cycle();
`endif

    // write then read-back, then idle hold
    drive(0, 1, 0, 16'h0003, 16'hBEEF);
    cycle();
    drive(0, 0, 1, 16'h0003, 16'h0000);
    cycle();
    chk("readback_3", dout, 16'hBEEF);
    drive(0, 1, 1, 16'h0007, 16'h1111);
    cycle();
    chk("idle_hold", dout, 16'hBEEF);

    // simultaneous read/write is write-through
    drive(0, 0, 0, 16'h0002, 16'h1234);
    cycle();
    chk("write_through", dout, 16'h1234);
    drive(0, 1, 1, 16'h0000, 16'h0000);
    cycle();
    drive(0, 0, 1, 16'h0002, 16'h0000);
    cycle();
    chk("readback_2", dout, 16'h1234);

    // out-of-range write and read
    drive(0, 1, 0, 16'h0010, 16'hFFFF);
    cycle();
    chk("oor_pulse", {15'd0, rerr}, 16'h0001);
    drive(0, 1, 1, 16'h0000, 16'h0000);
    cycle();
    chk("oor_pulse_end", {15'd0, rerr}, 16'h0000);
    drive(0, 0, 1, 16'h0000, 16'h0000);
    cycle();
`ifdef SRAM_INIT_EN
    chk("mem0_kept", dout, 16'h1000);
`else
    chk("mem0_kept", dout, 16'h5A5A);
`endif
    drive(0, 0, 1, 16'h0010, 16'h0000);
    cycle();
    chk("oor_read", dout, 16'h0000);
    chk("oor_read_err", {15'd0, rerr}, 16'h0001);

    // read-after-write on consecutive edges
    drive(0, 1, 0, 16'h000A, 16'h7E57);
    cycle();
    drive(0, 0, 1, 16'h000A, 16'h0000);
    cycle();
    chk("raw_next_edge", dout, 16'h7E57);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra;
      if ($urandom_range(0, 7) == 0) ra = 16'($urandom) | 16'h0010;
      else                           ra = 16'($urandom_range(0, 15));
      drive(0, 1'($urandom), 1'($urandom), ra, 16'($urandom));
      cycle();
    end

    // reset does not clear memory
    drive(0, 1, 0, 16'h000C, 16'hA5C3);
    cycle();
    drive(1, 1, 1, 16'h0000, 16'h0000);
    cycle();
    drive(0, 1, 1, 16'h0000, 16'h0000);
    n = 0;
    while (busy && n < 40) begin
      n++;
      cycle();
    end
    drive(0, 0, 1, 16'h000C, 16'h0000);
    cycle();
`ifdef SRAM_INIT_EN
    chk("mem_after_reset", dout, 16'h100C);
`else
    chk("mem_after_reset", dout, 16'hA5C3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
